// File: rtl/t03_mem_arbiter.sv
// Fetch / load-store arbiter in front of the single-request wishbone_manager port.
// One transaction in flight; data has priority until a pending fetch has been passed over STARVE_MAX times.
module t03_mem_arbiter #(
  parameter int STARVE_MAX  = 4,
  parameter int ACC_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        en,
  input  logic        i_req,
  input  logic [31:0] i_adr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  output logic        i_err,
  input  logic        d_ren,
  input  logic        d_wen,
  input  logic [31:0] d_adr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_sel,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic [31:0] ADR_I,
  output logic [31:0] CPU_DAT_I,
  output logic [3:0]  SEL_I,
  output logic        READ_I,
  output logic        WRITE_I,
  input  logic [31:0] CPU_DAT_O,
  input  logic        BUSY_O
);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP, S_ABORT} state_e;
  typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} own_e;

  // Timeout counter only needs to hold 0..ACC_TIMEOUT-1.
  localparam int TW = (ACC_TIMEOUT > 1) ? $clog2(ACC_TIMEOUT) : 1;
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [TW-1:0] TMO_LAST   = TW'(ACC_TIMEOUT - 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  state_e      state_q, state_d;
  own_e        owner_q, owner_d;
  logic [31:0] adr_q, adr_d, dat_q, dat_d;
  logic [3:0]  sel_q, sel_d;
  logic        rd_q, rd_d, wr_q, wr_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [SW-1:0] starve_q, starve_d;
  logic        i_ack_q, i_ack_d, d_ack_q, d_ack_d;
  logic        i_err_q, i_err_d, d_err_q, d_err_d;
  logic [31:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;

  logic d_any, take_i;
  assign d_any  = d_ren | d_wen;
  assign take_i = i_req & (~d_any | (starve_q == STARVE_LIM));

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    sel_d     = sel_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    tmo_d     = tmo_q;
    starve_d  = i_req ? starve_q : '0;
    i_ack_d   = 1'b0;
    d_ack_d   = 1'b0;
    i_err_d   = 1'b0;
    d_err_d   = 1'b0;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (en && (i_req || d_any)) begin
          tmo_d = '0;
          if (take_i) begin
            owner_d  = OWN_I;
            adr_d    = i_adr;
            dat_d    = '0;
            sel_d    = 4'hF;
            rd_d     = 1'b1;
            wr_d     = 1'b0;
            starve_d = '0;
            state_d  = S_ISSUE;
          end else begin
            owner_d = OWN_D;
            adr_d   = d_adr;
            dat_d   = d_wdata;
            sel_d   = d_sel;
            if (i_req && starve_q != STARVE_LIM) starve_d = starve_q + 1'b1;
            // A store with no byte lanes enabled never touches the bus.
            if (d_wen && d_sel == 4'h0) begin
              rd_d    = 1'b0;
              wr_d    = 1'b0;
              d_ack_d = 1'b1;
              state_d = S_RESP;
            end else begin
              rd_d    = ~d_wen;
              wr_d    = d_wen;
              state_d = S_ISSUE;
            end
          end
        end
      end
      S_ISSUE: begin
        if (BUSY_O) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          state_d = S_WAIT;
        end else if (tmo_q == TMO_LAST) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          state_d = S_ABORT;
          if (owner_q == OWN_D) d_err_d = 1'b1;
          else                  i_err_d = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_WAIT: begin
        if (!BUSY_O) begin
          if (owner_q == OWN_D) begin
            d_rdata_d = CPU_DAT_O;
            d_ack_d   = 1'b1;
          end else begin
            i_rdata_d = CPU_DAT_O;
            i_ack_d   = 1'b1;
          end
          state_d = S_RESP;
        end
      end
      S_RESP, S_ABORT: begin
        owner_d = OWN_NONE;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= S_IDLE;
      owner_q   <= OWN_NONE;
      adr_q     <= '0;
      dat_q     <= '0;
      sel_q     <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      tmo_q     <= '0;
      starve_q  <= '0;
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      i_err_q   <= 1'b0;
      d_err_q   <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      sel_q     <= sel_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      tmo_q     <= tmo_d;
      starve_q  <= starve_d;
      i_ack_q   <= i_ack_d;
      d_ack_q   <= d_ack_d;
      i_err_q   <= i_err_d;
      d_err_q   <= d_err_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  assign ADR_I     = adr_q;
  assign CPU_DAT_I = dat_q;
  assign SEL_I     = sel_q;
  assign READ_I    = rd_q;
  assign WRITE_I   = wr_q;
  assign i_ack     = i_ack_q;
  assign d_ack     = d_ack_q;
  assign i_err     = i_err_q;
  assign d_err     = d_err_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;

endmodule
